// File: rtl/lut_ctrl_pkg.sv
// Shared LUT geometry and line type for the LUT access scheduler.
package lut_ctrl_pkg;

  localparam int LUT_ADDR_W  = 6;
  localparam int LUT_WORDS   = 4;
  localparam int LUT_DATA_W  = 32;
  localparam int LUT_ENTRIES = 36;

  typedef logic [LUT_DATA_W-1:0] lut_line_t [0:LUT_WORDS-1];

endpackage

// File: rtl/lut_access_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps,
// returning a one-hot grant (all zero when nothing is requested).
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant = '0;
    idx   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        grant = N'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/lut_access_sched.sv
// Schedules one loader write port and NUM_RD read requesters onto a single
// LUT port: writes first with a bounded burst, reads round-robin, and a
// two-stage pipeline (LUT strobe, then registered response).
module lut_access_sched
  import lut_ctrl_pkg::lut_line_t;
  import lut_ctrl_pkg::LUT_ADDR_W;
#(
  parameter int NUM_RD       = 2,
  parameter int WR_BURST_MAX = 4,
  parameter int LUT_ENTRIES  = lut_ctrl_pkg::LUT_ENTRIES,
  localparam int ID_W        = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [LUT_ADDR_W-1:0]            wr_base,
  input  lut_line_t                        wr_data,
  input  logic [NUM_RD-1:0]                rd_valid,
  output logic [NUM_RD-1:0]                rd_ready,
  input  logic [NUM_RD-1:0][LUT_ADDR_W-1:0] rd_base,
  output logic                             rsp_valid,
  output logic [ID_W-1:0]                  rsp_id,
  output lut_line_t                        rsp_data,
  output logic                             lut_en_write,
  output logic                             lut_en_read,
  output logic [LUT_ADDR_W-1:0]            lut_base,
  output lut_line_t                        lut_wdata,
  input  lut_line_t                        lut_rdata,
  output logic                             err_oob
);

  // Handshake: a request is taken in the cycle where its valid and ready are
  // both high. Ready depends only on the valids and internal state (never on
  // the base), at most one ready is high per cycle, and all are low in reset.

  localparam int BW = $clog2(WR_BURST_MAX + 1);

  logic [BW-1:0]         burst_cnt;
  logic [ID_W-1:0]       rr_ptr;
  logic [NUM_RD-1:0]     arb_gnt;
  logic [ID_W-1:0]       gnt_idx;
  logic [ID_W-1:0]       s1_id;
  logic [LUT_ADDR_W-1:0] acc_base;
  logic                  rd_any;
  logic                  burst_full;
  logic                  read_turn;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  in_range;

  assign rd_any     = |rd_valid;
  assign burst_full = (burst_cnt == BW'(WR_BURST_MAX));
  // Reads win when no write is offered or the write burst has used its quota.
  assign read_turn  = rd_any && (!wr_valid || burst_full);
  assign wr_ready   = rst_n && wr_valid && !read_turn;
  assign rd_ready   = (rst_n && read_turn) ? arb_gnt : '0;
  assign wr_acc     = wr_ready;
  assign rd_acc     = |rd_ready;

  rr_arbiter #(
    .N  (NUM_RD),
    .PW (ID_W)
  ) u_rr_arbiter (
    .req   (rd_valid),
    .ptr   (rr_ptr),
    .grant (arb_gnt)
  );

  // Encode the one-hot arbiter grant and select the accepted base.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (arb_gnt[i]) begin
        gnt_idx = ID_W'(i);
      end
    end
    acc_base = wr_acc ? wr_base : rd_base[gnt_idx];
    in_range = 32'(acc_base) < LUT_ENTRIES;
  end

  // Burst counter and round-robin pointer (pointer = next index searched first).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst_cnt <= '0;
      rr_ptr    <= '0;
    end else begin
      if (!rd_any || rd_acc) begin
        burst_cnt <= '0;
      end else if (wr_acc) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
      if (rd_acc) begin
        rr_ptr <= (32'(gnt_idx) == NUM_RD - 1) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // Stage 1: LUT strobes and registered copy of the accepted request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lut_en_write <= 1'b0;
      lut_en_read  <= 1'b0;
      lut_base     <= '0;
      lut_wdata    <= '{default: '0};
      s1_id        <= '0;
      err_oob      <= 1'b0;
    end else begin
      lut_en_write <= wr_acc && in_range;
      lut_en_read  <= rd_acc && in_range;
      if ((wr_acc || rd_acc) && in_range) begin
        lut_base <= acc_base;
        s1_id    <= gnt_idx;
      end
      if (wr_acc && in_range) begin
        lut_wdata <= wr_data;
      end
      if ((wr_acc || rd_acc) && !in_range) begin
        err_oob <= 1'b1;
      end
    end
  end

  // Stage 2: capture the combinational LUT read data into the response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '{default: '0};
    end else begin
      rsp_valid <= lut_en_read;
      if (lut_en_read) begin
        rsp_id   <= s1_id;
        rsp_data <= lut_rdata;
      end
    end
  end

endmodule

// File: tb/tb_lut_access_sched.sv
// Bench for lut_access_sched: directed scenarios plus random traffic, all
// checked every cycle against an acceptance-order reference model.
module tb_lut_access_sched;
  import lut_ctrl_pkg::*;

  localparam int NRD  = 2;
  localparam int BMAX = 4;
  localparam int NENT = 36;

  logic                 clk;
  logic                 rst_n;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [5:0]           wr_base;
  lut_line_t            wr_data;
  logic [NRD-1:0]       rd_valid;
  logic [NRD-1:0]       rd_ready;
  logic [NRD-1:0][5:0]  rd_base;
  logic                 rsp_valid;
  logic [0:0]           rsp_id;
  lut_line_t            rsp_data;
  logic                 lut_en_write;
  logic                 lut_en_read;
  logic [5:0]           lut_base;
  lut_line_t            lut_wdata;
  lut_line_t            lut_rdata;
  logic                 err_oob;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  lut_access_sched #(
    .NUM_RD       (NRD),
    .WR_BURST_MAX (BMAX),
    .LUT_ENTRIES  (NENT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_base      (wr_base),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_base      (rd_base),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .lut_en_write (lut_en_write),
    .lut_en_read  (lut_en_read),
    .lut_base     (lut_base),
    .lut_wdata    (lut_wdata),
    .lut_rdata    (lut_rdata),
    .err_oob      (err_oob)
  );

  // ---------------- clock / reset block ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic logic [127:0] pk(input lut_line_t l);
    return {l[0], l[1], l[2], l[3]};
  endfunction

  function automatic lut_line_t line_init(input int i);
    lut_line_t l;
    for (int k = 0; k < 4; k++) l[k] = 32'hA000_0000 | 32'(i << 8) | 32'(k);
    return l;
  endfunction

  task automatic chk(input string nm, input logic [128:0] act, input logic [128:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- LUT table model ----------------
  lut_line_t lut_mem [64];
  logic      mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) lut_mem[i] <= line_init(i);
      mem_ready <= 1'b1;
    end else if (lut_en_write) begin
      lut_mem[lut_base] <= lut_wdata;
    end
  end

  always_comb begin
    lut_rdata = '{default: '0};
    if (lut_en_read) lut_rdata = lut_mem[lut_base];
  end

  // ---------------- reference model + scoreboard ----------------
  logic [128:0] exp_q[$];
  int           due_q[$];
  lut_line_t    m_mem [64];
  logic         m_init = 1'b0;
  logic         chk_en = 1'b0;
  int           m_burst;
  int           m_last;
  logic         m_err;
  logic         cur_w, cur_r;
  logic [5:0]   cur_base;
  lut_line_t    cur_wdata;

  // observation logs used by the directed scenarios
  int           gnt_q[$];
  int           rdp_q[$];
  int           rsp_cyc_q[$];
  int           rsp_id_q[$];
  logic [127:0] rsp_dat_q[$];
  int           wacc_n;

  always @(negedge clk) begin
    logic           any_rd, rturn, e_wr_rdy, inr;
    logic [NRD-1:0] e_rd_rdy;
    logic [128:0]   e;
    logic [5:0]     b;
    int             gi, j;

    if (!m_init) begin
      for (int i = 0; i < 64; i++) m_mem[i] = line_init(i);
      m_init = 1'b1;
    end

    // registered outputs, reflecting what was accepted last cycle
    if (chk_en) begin
      chk("lut_en_write", lut_en_write, cur_w);
      chk("lut_en_read", lut_en_read, cur_r);
      chk("lut_base", lut_base, cur_base);
      if (cur_w) chk("lut_wdata", pk(lut_wdata), pk(cur_wdata));
      chk("err_oob", err_oob, m_err);
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        chk("rsp_valid", rsp_valid, 1'b1);
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        chk("rsp_id_data", {rsp_id, pk(rsp_data)}, e);
      end else begin
        chk("rsp_valid", rsp_valid, 1'b0);
      end
      if (rsp_valid) begin
        rsp_cyc_q.push_back(cyc);
        rsp_id_q.push_back(int'(rsp_id));
        rsp_dat_q.push_back(pk(rsp_data));
      end
      if (lut_en_read) rdp_q.push_back(cyc);
      if (wr_valid && wr_ready) wacc_n++;
      for (int i = 0; i < NRD; i++) if (rd_ready[i]) gnt_q.push_back(i);
    end

    // who should be granted this cycle
    any_rd   = |rd_valid;
    rturn    = any_rd && (!wr_valid || m_burst == BMAX);
    e_wr_rdy = rst_n && wr_valid && !rturn;
    e_rd_rdy = '0;
    gi       = -1;
    if (rst_n && rturn) begin
      for (int k = 1; k <= NRD; k++) begin
        j = (m_last + k) % NRD;
        if (gi < 0 && rd_valid[j]) gi = j;
      end
    end
    if (gi >= 0) e_rd_rdy[gi] = 1'b1;
    if (chk_en) begin
      chk("wr_ready", wr_ready, e_wr_rdy);
      chk("rd_ready", rd_ready, e_rd_rdy);
    end

    // advance the model
    if (!rst_n) begin
      cur_w = 0; cur_r = 0; cur_base = '0; cur_wdata = '{default: '0};
      m_err = 0; m_burst = 0; m_last = NRD - 1;
      exp_q.delete(); due_q.delete();
      chk_en = 1'b1;
    end else begin
      cur_w = 0;
      cur_r = 0;
      if (e_wr_rdy) begin
        b   = wr_base;
        inr = 32'(b) < NENT;
        if (inr) begin
          m_mem[b] = wr_data; cur_w = 1; cur_base = b; cur_wdata = wr_data;
        end else m_err = 1;
        if (any_rd) m_burst++;
      end else if (gi >= 0) begin
        b   = rd_base[gi];
        inr = 32'(b) < NENT;
        if (inr) begin
          exp_q.push_back({1'(gi), pk(m_mem[b])});
          due_q.push_back(cyc + 2);
          cur_r = 1; cur_base = b;
        end else m_err = 1;
        m_burst = 0;
        m_last  = gi;
      end
      if (!any_rd) m_burst = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    gnt_q.delete(); rdp_q.delete(); rsp_cyc_q.delete();
    rsp_id_q.delete(); rsp_dat_q.delete(); wacc_n = 0;
  endtask

  task automatic idle();
    wr_valid = 1'b0;
    rd_valid = '0;
  endtask

  function automatic logic [5:0] rand_base();
    if ($urandom_range(0, 19) == 0) return 6'($urandom_range(36, 63));
    return 6'($urandom_range(0, 35));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int t_rd, t0;
    int exp_g[6];
    lut_line_t d23;
    exp_g = '{0, 1, 0, 1, 0, 1};
    d23   = '{32'h01FE0000, 32'h02FFFFFB, 32'hFFFB0001, 32'hFF00FF00};

    rst_n = 1'b0; wr_base = '0; wr_data = '{default: '0}; rd_base = '0;
    idle();
    repeat (3) step();
    chk("reset_ctrl", {wr_ready, rd_ready, lut_en_write, lut_en_read, rsp_valid, rsp_id, err_oob, lut_base}, '0);
    chk("reset_rsp_data", pk(rsp_data), '0);
    chk("reset_lut_wdata", pk(lut_wdata), '0);
    rst_n = 1'b1;
    step();

    // single write then read of the same line
    clear_logs();
    wr_valid = 1'b1; wr_base = 6'd5; wr_data = d23;
    step();
    wr_valid = 1'b0; rd_valid = 2'b10; rd_base[1] = 6'd5; t_rd = cyc;
    step();
    idle();
    repeat (4) step();
    chk("wr_rd_rsp_count", rsp_cyc_q.size(), 1);
    if (rsp_cyc_q.size() == 1) begin
      chk("wr_rd_latency", rsp_cyc_q[0] - t_rd, 2);
      chk("wr_rd_id", rsp_id_q[0], 1);
      chk("wr_rd_data", rsp_dat_q[0], pk(d23));
    end

    // round-robin between two always-requesting readers
    clear_logs();
    rd_valid = 2'b11; rd_base[0] = 6'd3; rd_base[1] = 6'd20;
    repeat (6) step();
    idle();
    repeat (3) step();
    chk("rr_grant_count", gnt_q.size(), 6);
    chk("rr_rsp_count", rsp_id_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < gnt_q.size()) chk("rr_grant_order", gnt_q[i], exp_g[i]);
      if (i < rsp_id_q.size()) chk("rr_rsp_order", rsp_id_q[i], exp_g[i]);
    end

    // starvation bound under a long write burst
    clear_logs();
    rd_valid = 2'b01; rd_base[0] = 6'd10; wr_valid = 1'b1; t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      wr_base = 6'($urandom_range(0, 30));
      for (int k = 0; k < 4; k++) wr_data[k] = $urandom;
      step();
    end
    idle();
    repeat (3) step();
    chk("burst_writes", wacc_n, 8);
    chk("burst_reads", rdp_q.size(), 2);
    if (rdp_q.size() == 2) begin
      chk("burst_rd_pulse0", rdp_q[0] - t0, 5);
      chk("burst_rd_pulse1", rdp_q[1] - t0, 10);
    end

    // out-of-range read followed by a valid one
    clear_logs();
    chk("oob_before", err_oob, 1'b0);
    rd_valid = 2'b01; rd_base[0] = 6'd36;
    step();
    rd_base[0] = 6'd35;
    step();
    idle();
    repeat (3) step();
    chk("oob_flag", err_oob, 1'b1);
    chk("oob_rd_pulses", rdp_q.size(), 1);
    chk("oob_rsp_count", rsp_id_q.size(), 1);
    if (rsp_dat_q.size() == 1) begin
      chk("oob_rsp_data", rsp_dat_q[0], 128'hA0002300_A0002301_A0002302_A0002303);
      chk("oob_rsp_id", rsp_id_q[0], 0);
    end

    // reset in the cycle after a read is accepted
    clear_logs();
    rd_valid = 2'b10; rd_base[1] = 6'd7;
    step();
    idle();
    rst_n = 1'b0;
    step();
    rd_valid = 2'b11;
    #1;
    chk("rst_mid_ctrl", {wr_ready, rd_ready, lut_en_write, lut_en_read, rsp_valid, rsp_id, err_oob, lut_base}, '0);
    chk("rst_mid_data", {pk(rsp_data), pk(lut_wdata)}, '0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_release_tie", rd_ready, 2'b01);
    step();
    idle();
    repeat (4) step();
    chk("rst_rsp_count", rsp_id_q.size(), 1);
    if (rsp_id_q.size() == 1) chk("rst_rsp_id", rsp_id_q[0], 0);

    // random traffic with one reset in the middle
    for (int i = 0; i < 400; i++) begin
      rst_n    = !(i == 200 || i == 201);
      wr_valid = ($urandom_range(0, 2) != 0);
      wr_base  = rand_base();
      for (int k = 0; k < 4; k++) wr_data[k] = $urandom;
      rd_valid = 2'($urandom_range(0, 3));
      rd_base[0] = rand_base();
      rd_base[1] = rand_base();
      step();
    end
    rst_n = 1'b1;
    idle();
    repeat (4) step();
    chk("final_exp_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
